camera_capture: RTL and testbench

Front-end capture stage between the sensor's parallel pixel bus and the Bayer-to-RGB converter. Qualifies raw 12-bit samples with the sensor frame and line valid strobes. Gates whole frames on start/stop commands. Emits each accepted pixel with its column/row coordinates, plus a completed-frame count.

---
 rtl/camera_capture_if.sv | 28 ++
 rtl/camera_capture.sv | 110 +++++++++++
 tb/tb_camera_capture.sv | 241 ++++++++++++++++++++++++
 3 files changed

// File: rtl/camera_capture_if.sv
// camera_capture_if: bundles the sensor pixel bus, capture commands and the
// qualified pixel output of camera_capture.
//   master : sensor/controller side (drives iDATA/iFVAL/iLVAL/iStart/iEnd)
//   slave  : camera_capture side (drives oDATA/oDVAL/oX_Cont/oY_Cont/
//            oFrame_Cont/oBusy)
interface camera_capture_if;
  logic [11:0] iDATA;
  logic        iFVAL;
  logic        iLVAL;
  logic        iStart;
  logic        iEnd;
  logic [11:0] oDATA;
  logic        oDVAL;
  logic [10:0] oX_Cont;
  logic [10:0] oY_Cont;
  logic [31:0] oFrame_Cont;
  logic        oBusy;

  modport master (
    output iDATA, iFVAL, iLVAL, iStart, iEnd,
    input  oDATA, oDVAL, oX_Cont, oY_Cont, oFrame_Cont, oBusy
  );

  modport slave (
    input  iDATA, iFVAL, iLVAL, iStart, iEnd,
    output oDATA, oDVAL, oX_Cont, oY_Cont, oFrame_Cont, oBusy
  );
endinterface

// File: rtl/camera_capture.sv
// camera_capture: qualifies raw 12-bit sensor samples with frame/line valid,
// gates whole frames on start/stop commands and tags each accepted pixel with
// its column/row, plus a count of completed captured frames.
//   iCLK        pixel clock, rising edge
//   iRST        asynchronous active-low reset
//   bus (slave) iDATA/iFVAL/iLVAL sensor bus, iStart/iEnd commands,
//               oDATA/oDVAL/oX_Cont/oY_Cont pixel out, oFrame_Cont, oBusy
// Parameter COLUMN_WIDTH: active pixels per line (column counter wrap).
// Macro CAMERA_CAPTURE_INPUT_REG_EN: adds one register stage on iDATA/iFVAL/
// iLVAL ahead of all logic (latency 2 instead of 1); iStart/iEnd undelayed.
module camera_capture #(
  parameter int unsigned COLUMN_WIDTH = 1280
) (
  input  logic              iCLK,
  input  logic              iRST,
  camera_capture_if.slave   bus
);

  typedef enum logic [1:0] {IDLE, ARMED, CAPTURING, STOPPING} state_t;

  localparam logic [10:0] LAST_COL = 11'(COLUMN_WIDTH - 1);

  state_t      state;
  logic [11:0] data;
  logic        fval;
  logic        lval;
  logic        prevFval;
  logic [10:0] xCnt;
  logic [10:0] yCnt;

`ifdef CAMERA_CAPTURE_INPUT_REG_EN
  // fval resets high alongside prevFval so a frame in progress at reset
  // release cannot look like a rising edge once it propagates through.
  always_ff @(posedge iCLK or negedge iRST) begin
    if (!iRST) begin
      data <= '0;
      fval <= 1'b1;
      lval <= 1'b0;
    end else begin
      data <= bus.iDATA;
      fval <= bus.iFVAL;
      lval <= bus.iLVAL;
    end
  end
`else
  assign data = bus.iDATA;
  assign fval = bus.iFVAL;
  assign lval = bus.iLVAL;
`endif

  logic fRise;
  logic fFall;
  logic active;
  logic accept;

  assign fRise  = fval & ~prevFval;
  assign fFall  = ~fval & prevFval;
  assign active = (state == CAPTURING) || (state == STOPPING);
  assign accept = active & fval & lval;

  assign bus.oBusy = (state != IDLE);

  always_ff @(posedge iCLK or negedge iRST) begin
    if (!iRST) begin
      state           <= IDLE;
      prevFval        <= 1'b1;
      xCnt            <= '0;
      yCnt            <= '0;
      bus.oDATA       <= '0;
      bus.oDVAL       <= 1'b0;
      bus.oX_Cont     <= '0;
      bus.oY_Cont     <= '0;
      bus.oFrame_Cont <= '0;
    end else begin
      prevFval  <= fval;
      bus.oDVAL <= accept;

      unique case (state)
        IDLE:      if (bus.iStart && !bus.iEnd) state <= ARMED;
        ARMED:     if (bus.iEnd) state <= IDLE;
                   else if (fRise) state <= CAPTURING;
        CAPTURING: if (bus.iEnd) state <= STOPPING;
        STOPPING:  if (fFall) state <= IDLE;
        default:   state <= IDLE;
      endcase

      // Coordinates are registered pre-increment so they describe oDATA.
      if (accept) begin
        bus.oDATA   <= data;
        bus.oX_Cont <= xCnt;
        bus.oY_Cont <= yCnt;
      end

      if (fRise) begin
        xCnt <= '0;
        yCnt <= '0;
      end else if (accept) begin
        if (xCnt == LAST_COL) begin
          xCnt <= '0;
          yCnt <= yCnt + 11'd1;
        end else begin
          xCnt <= xCnt + 11'd1;
        end
      end

      if (active && fFall) bus.oFrame_Cont <= bus.oFrame_Cont + 32'd1;
    end
  end

endmodule

// File: tb/tb_camera_capture.sv
module tb_camera_capture;
  localparam int W = 8;

  bit clk = 1'b0;
  bit rst = 1'b0;
  always #5 clk = ~clk;

  camera_capture_if bus();

  camera_capture #(.COLUMN_WIDTH(W)) dut (
    .iCLK (clk),
    .iRST (rst),
    .bus  (bus)
  );

  int checks = 0;
  int errors = 0;
  int dvals  = 0;
  logic [33:0] pixQ[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: capture mode flags plus a per-frame accepted-pixel index;
  // coordinates come from index arithmetic.
  bit          armed = 0, inFrame = 0, stopReq = 0, pf = 1;
  int          pix = 0;
  logic [31:0] frames = '0;
  bit          eDval = 0, eBusy = 0;
  logic [11:0] eData = '0;
  logic [10:0] eX = '0, eY = '0;
  bit          mf, ml, rise, fall;
  logic [11:0] md;
  bit          dF = 1, dL = 0;
  logic [11:0] dD = '0;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      armed = 0; inFrame = 0; stopReq = 0; pf = 1; pix = 0; frames = '0;
      eDval = 0; eBusy = 0; eData = '0; eX = '0; eY = '0;
      dF = 1; dL = 0; dD = '0;
    end else begin
`ifdef CAMERA_CAPTURE_INPUT_REG_EN
      mf = dF; ml = dL; md = dD;
      dF = bus.iFVAL; dL = bus.iLVAL; dD = bus.iDATA;
`else
      mf = bus.iFVAL; ml = bus.iLVAL; md = bus.iDATA;
`endif
      rise = mf && !pf;
      fall = !mf && pf;
      eDval = inFrame && mf && ml;
      if (eDval) begin
        eData = md;
        eX = 11'(pix % W);
        eY = 11'((pix / W) % 2048);
        pix++;
      end
      if (rise) pix = 0;
      if (inFrame && fall) frames = frames + 1;
      if (!armed && !inFrame) begin
        if (bus.iStart && !bus.iEnd) armed = 1;
      end else if (armed) begin
        if (bus.iEnd) armed = 0;
        else if (rise) begin armed = 0; inFrame = 1; stopReq = 0; end
      end else if (!stopReq) begin
        if (bus.iEnd) stopReq = 1;
      end else if (fall) begin
        inFrame = 0; stopReq = 0;
      end
      eBusy = armed || inFrame;
      pf = mf;
    end
  end

  always @(negedge clk) begin
    chk("dval", bus.oDVAL, eDval);
    chk("busy", bus.oBusy, eBusy);
    chk("frames", bus.oFrame_Cont, frames);
    if (eDval) begin
      chk("data", bus.oDATA, eData);
      chk("x", bus.oX_Cont, eX);
      chk("y", bus.oY_Cont, eY);
    end
    if (!rst) begin
      chk("rst_data", bus.oDATA, 0);
      chk("rst_xy", {bus.oX_Cont, bus.oY_Cont}, 0);
    end
    if (bus.oDVAL === 1'b1) begin
      dvals++;
      pixQ.push_back({bus.oY_Cont, bus.oX_Cont, bus.oDATA});
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse(input bit s, input bit e);
    bus.iStart = s; bus.iEnd = e;
    tick();
    bus.iStart = 0; bus.iEnd = 0;
  endtask

  task automatic frame(input int lines, input int len, input bit pat, input int endLine);
    bus.iFVAL = 1;
    repeat (3) tick();
    for (int r = 0; r < lines; r++) begin
      for (int c = 0; c < len; c++) begin
        bus.iLVAL = 1;
        bus.iDATA = pat ? 12'(c + 16 * r) : 12'($urandom);
        bus.iEnd  = (r == endLine && c == 2);
        tick();
      end
      bus.iLVAL = 0; bus.iEnd = 0;
      repeat (2) tick();
    end
    bus.iFVAL = 0;
    repeat (3) tick();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  int base;

  initial begin
    bus.iDATA = '0; bus.iFVAL = 1; bus.iLVAL = 0; bus.iStart = 0; bus.iEnd = 0;
    repeat (4) tick();
    // Frame in progress at reset release must be skipped.
    rst = 1;
    base = dvals;
    bus.iLVAL = 1; repeat (W) begin bus.iDATA = 12'($urandom); tick(); end
    bus.iLVAL = 0; tick();
    pulse(1, 0);
    bus.iLVAL = 1; repeat (W) begin bus.iDATA = 12'($urandom); tick(); end
    bus.iLVAL = 0; tick();
    bus.iFVAL = 0; repeat (3) tick();
    chk("partial_dvals", dvals - base, 0);
    frame(4, W, 0, -1);
    chk("frame1_dvals", dvals - base, 32);
    chk("frame1_count", bus.oFrame_Cont, 1);

    // Coordinate pattern frame; capture continues after frame 1.
    pixQ.delete();
    frame(3, W, 1, -1);
    chk("pat_size", pixQ.size(), 24);
    chk("pat_first", pixQ[0], {11'd0, 11'd0, 12'd0});
    chk("pat_mid", pixQ[9], {11'd1, 11'd1, 12'd17});
    chk("pat_last", pixQ[23], {11'd2, 11'd7, 12'd39});
    chk("pat_count", bus.oFrame_Cont, 2);

    // Stop requested mid-frame 2 of 3.
    frame(3, W, 0, -1);
    frame(3, W, 0, 1);
    base = dvals;
    frame(3, W, 0, -1);
    chk("stop_dvals", dvals - base, 0);
    chk("stop_count", bus.oFrame_Cont, 4);
    chk("stop_busy", bus.oBusy, 0);

    // Start+end together in IDLE; end while ARMED.
    pulse(1, 1);
    tick();
    chk("both_busy", bus.oBusy, 0);
    pulse(1, 0);
    chk("armed_busy", bus.oBusy, 1);
    pulse(0, 1);
    chk("disarm_busy", bus.oBusy, 0);
    base = dvals;
    frame(2, W, 0, -1);
    chk("disarm_dvals", dvals - base, 0);
    chk("disarm_count", bus.oFrame_Cont, 4);

    // Line valid without frame valid while armed.
    pulse(1, 0);
    base = dvals;
    bus.iLVAL = 1;
    repeat (5) begin bus.iDATA = 12'($urandom); tick(); end
    bus.iLVAL = 0; tick();
    chk("orphan_dvals", dvals - base, 0);
    pixQ.delete();
    frame(2, W, 1, -1);
    chk("orphan_first", pixQ[0], {11'd0, 11'd0, 12'd0});
    chk("orphan_count", bus.oFrame_Cont, 5);

    // Reset asserted at pixel (3,1).
    bus.iFVAL = 1; repeat (3) tick();
    for (int c = 0; c < W; c++) begin bus.iLVAL = 1; bus.iDATA = 12'(c); tick(); end
    bus.iLVAL = 0; repeat (2) tick();
    for (int c = 0; c < 4; c++) begin bus.iLVAL = 1; bus.iDATA = 12'(16 + c); tick(); end
    chk("pre_rst_x", bus.oX_Cont, 3);
    chk("pre_rst_y", bus.oY_Cont, 1);
    #2 rst = 0;
    #1;
    chk("rst_dval", bus.oDVAL, 0);
    chk("rst_count", bus.oFrame_Cont, 0);
    chk("rst_busy", bus.oBusy, 0);
    chk("rst_xy_now", {bus.oX_Cont, bus.oY_Cont, bus.oDATA}, 0);
    base = dvals;
    repeat (3) tick();
    rst = 1;
    for (int c = 0; c < W; c++) begin bus.iDATA = 12'($urandom); tick(); end
    bus.iLVAL = 0; tick();
    bus.iFVAL = 0; repeat (3) tick();
    frame(2, W, 0, -1);
    chk("post_rst_dvals", dvals - base, 0);
    pulse(1, 0);
    frame(2, W, 0, -1);
    chk("restart_dvals", dvals - base, 16);
    chk("restart_count", bus.oFrame_Cont, 1);

    // Randomized traffic checked cycle by cycle against the model.
    for (int i = 0; i < 30; i++) begin
      case ($urandom_range(0, 4))
        0: pulse(1, 0);
        1: pulse(0, 1);
        2: pulse(1, 1);
        default: tick();
      endcase
      if ($urandom_range(0, 3) == 0) begin
        bus.iLVAL = 1;
        repeat ($urandom_range(1, 4)) begin bus.iDATA = 12'($urandom); tick(); end
        bus.iLVAL = 0;
      end
      frame($urandom_range(1, 4), $urandom_range(1, W + 3), 0, $urandom_range(0, 6));
    end

    tick();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
